// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU opcode bit positions and bundle layouts for the execute stage.
// The ID bundle carries 32 spare LSBs below gr_we that EX does not interpret.
package ex_stage_pkg;

  localparam int to_EX_data_width  = 182;
  localparam int to_MEM_data_width = 71;
  localparam int EX_forward_width  = 38;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] imm;
    logic [11:0] alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        mem_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic        gr_we;
    logic [31:0] spare;
  } ex_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic        gr_we;
  } mem_bundle_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] value;
    logic        is_load;
  } forward_t;

endpackage

// File: rtl/ex_stage_if.sv
// Signals between ID, EX, MEM and the data SRAM as seen by the execute stage.
// slave is the EX side; master is the surrounding pipeline.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic                         ID_to_EX_valid;
  logic [to_EX_data_width-1:0]  to_EX_data;
  logic                         EX_allow_in;
  logic                         MEM_allow_in;
  logic                         EX_to_MEM_valid;
  logic [to_MEM_data_width-1:0] to_MEM_data;
  logic [EX_forward_width-1:0]  EX_forward;
  logic                         data_sram_en;
  logic [3:0]                   data_sram_we;
  logic [31:0]                  data_sram_addr;
  logic [31:0]                  data_sram_wdata;

  modport slave (
    input  ID_to_EX_valid, to_EX_data, MEM_allow_in,
    output EX_allow_in, EX_to_MEM_valid, to_MEM_data, EX_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ID_to_EX_valid, to_EX_data, MEM_allow_in,
    input  EX_allow_in, EX_to_MEM_valid, to_MEM_data, EX_forward,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU selected by a one-hot alu_op; an all-zero op yields zero.
module alu
  import ex_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [4:0]  shamt;

  assign shamt    = src2[4:0];
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sll_res  = src1 << shamt;
  assign srl_res  = src1 >> shamt;
  assign sra_res  = $signed(src1) >>> shamt;

  // AND-OR mux: each op contributes only when its one-hot bit is set
  always_comb begin
    result = ({32{alu_op[ALU_ADD]}}  & add_res)
           | ({32{alu_op[ALU_SUB]}}  & sub_res)
           | ({32{alu_op[ALU_SLT]}}  & slt_res)
           | ({32{alu_op[ALU_SLTU]}} & sltu_res)
           | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
           | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
           | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
           | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
           | ({32{alu_op[ALU_SLL]}}  & sll_res)
           | ({32{alu_op[ALU_SRL]}}  & srl_res)
           | ({32{alu_op[ALU_SRA]}}  & sra_res)
           | ({32{alu_op[ALU_LUI]}}  & src2);
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: pipeline register, valid/allow_in handshake, ALU, data SRAM
// request and result forwarding back to ID.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  ex_stage_if.slave bus
);

  localparam logic ex_ready_go = 1'b1;

  logic        ex_valid;
  ex_bundle_t  bundle;
  logic        ex_allow_in;
  logic        fire;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  mem_bundle_t mem_out;
  forward_t    fwd_out;
  logic        unused_spare;

  assign ex_allow_in = ~ex_valid | (ex_ready_go & bus.MEM_allow_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      bundle   <= '0;
    end else begin
      if (ex_allow_in)
        ex_valid <= bus.ID_to_EX_valid;
      if (bus.ID_to_EX_valid && ex_allow_in)
        bundle <= bus.to_EX_data;
    end
  end

  assign src1 = bundle.src1_is_pc  ? bundle.pc  : bundle.rj_value;
  assign src2 = bundle.src2_is_imm ? bundle.imm : bundle.rkd_value;

  alu u_alu (
    .alu_op (bundle.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (alu_result)
  );

  // Requests only go out in the cycle MEM takes the instruction, so a stalled
  // store is written once, on release
  assign fire = ex_valid & bus.MEM_allow_in;

  always_comb begin
    mem_out.pc           = bundle.pc;
    mem_out.alu_result   = alu_result;
    mem_out.res_from_mem = bundle.res_from_mem;
    mem_out.dest         = bundle.dest;
    mem_out.gr_we        = bundle.gr_we;
    fwd_out              = '0;
    if (ex_valid) begin
      fwd_out.dest    = bundle.dest;
      fwd_out.value   = alu_result;
      fwd_out.is_load = bundle.res_from_mem;
    end
  end

  assign bus.EX_allow_in     = ex_allow_in;
  assign bus.EX_to_MEM_valid = ex_valid & ex_ready_go;
  assign bus.to_MEM_data     = mem_out;
  assign bus.EX_forward      = fwd_out;
  assign bus.data_sram_en    = fire & (bundle.mem_we | bundle.res_from_mem);
  assign bus.data_sram_we    = {4{fire & bundle.mem_we}};
  assign bus.data_sram_addr  = alu_result;
  assign bus.data_sram_wdata = bundle.rkd_value;

  assign unused_spare = ^bundle.spare;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage; a queue-based model of the stage
// occupancy predicts every output on each falling edge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic [31:0] imm;
    logic [11:0] op;
    logic        s1pc;
    logic        s2imm;
    logic        we;
    logic        rfm;
    logic [4:0]  dest;
    logic        gr;
    logic [31:0] spare;
  } instr_t;

  logic   clk = 1'b0;
  logic   reset;
  int     checks;
  int     errors;
  bit     cmp_en;
  instr_t offer;
  instr_t model_q[$];

  ex_stage_if bus();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 12'h0) return 32'h0;
    if (op[0])  return a + b;
    if (op[1])  return a - b;
    if (op[2])  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
    if (op[3])  return (a < b) ? 32'h1 : 32'h0;
    if (op[4])  return a & b;
    if (op[5])  return ~(a | b);
    if (op[6])  return a | b;
    if (op[7])  return a ^ b;
    if (op[8])  return a << b[4:0];
    if (op[9])  return a >> b[4:0];
    if (op[10]) return $signed(a) >>> b[4:0];
    return b;
  endfunction

  function automatic logic [181:0] make_bundle(input instr_t i);
    return {i.pc, i.rj, i.rkd, i.imm, i.op, i.s1pc, i.s2imm, i.we, i.rfm, i.dest, i.gr, i.spare};
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] rj, input logic [31:0] rkd,
                                input logic [31:0] imm, input logic [11:0] op, input logic s1pc,
                                input logic s2imm, input logic we, input logic rfm, input logic [4:0] dest);
    instr_t i;
    i.pc = pc; i.rj = rj; i.rkd = rkd; i.imm = imm; i.op = op;
    i.s1pc = s1pc; i.s2imm = s2imm; i.we = we; i.rfm = rfm;
    i.dest = dest; i.gr = (dest != 5'd0); i.spare = 32'h0;
    return i;
  endfunction

  function automatic logic [31:0] pick_value();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 12);
    i.pc = $urandom; i.rj = pick_value(); i.rkd = pick_value(); i.imm = pick_value();
    i.op = (k == 12) ? 12'h0 : (12'h1 << k);
    i.s1pc = ($urandom_range(0, 3) == 0); i.s2imm = $urandom_range(0, 1);
    i.we = 1'b0; i.rfm = 1'b0; i.spare = $urandom;
    case ($urandom_range(0, 3))
      0: begin i.op = 12'h1; i.rfm = 1'b1; end
      1: begin i.op = 12'h1; i.we = 1'b1; end
      default: ;
    endcase
    i.gr = ~i.we & $urandom_range(0, 1);
    i.dest = i.gr ? 5'($urandom_range(1, 31)) : 5'd0;
    return i;
  endfunction

  task automatic applyStimulus(input logic v, input instr_t ins, input logic mem_allow);
    offer                 = ins;
    bus.ID_to_EX_valid    = v;
    bus.to_EX_data        = make_bundle(ins);
    bus.MEM_allow_in      = mem_allow;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: EX holds at most one instruction; it leaves when MEM accepts and a
  // new one enters when the stage is empty or draining
  always @(posedge clk) begin
    if (reset)
      model_q.delete();
    else if (model_q.size() != 0 && bus.MEM_allow_in) begin
      void'(model_q.pop_front());
      if (bus.ID_to_EX_valid) model_q.push_back(offer);
    end else if (model_q.size() == 0 && bus.ID_to_EX_valid)
      model_q.push_back(offer);
  end

  task automatic compareAll();
    logic        v;
    logic [31:0] r;
    instr_t      i;
    v = (model_q.size() != 0);
    checkOutput("allow_in", {127'b0, bus.EX_allow_in}, {127'b0, !v || bus.MEM_allow_in});
    checkOutput("to_mem_valid", {127'b0, bus.EX_to_MEM_valid}, {127'b0, v});
    if (v) begin
      i = model_q[0];
      r = ref_alu(i.op, i.s1pc ? i.pc : i.rj, i.s2imm ? i.imm : i.rkd);
      checkOutput("to_mem_data", 128'(bus.to_MEM_data), 128'({i.pc, r, i.rfm, i.dest, i.gr}));
      checkOutput("forward", 128'(bus.EX_forward), 128'({i.dest, r, i.rfm}));
      checkOutput("sram_en", {127'b0, bus.data_sram_en}, {127'b0, bus.MEM_allow_in && (i.we || i.rfm)});
      checkOutput("sram_we", 128'(bus.data_sram_we), 128'({4{bus.MEM_allow_in && i.we}}));
      if (i.we || i.rfm) begin
        checkOutput("sram_addr", 128'(bus.data_sram_addr), 128'(r));
        checkOutput("sram_wdata", 128'(bus.data_sram_wdata), 128'(i.rkd));
      end
    end else begin
      checkOutput("idle_sram_en", {127'b0, bus.data_sram_en}, 128'h0);
      checkOutput("idle_sram_we", 128'(bus.data_sram_we), 128'h0);
      checkOutput("idle_forward", 128'(bus.EX_forward), 128'h0);
    end
  endtask

  always @(negedge clk) if (cmp_en) compareAll();

  task automatic issue(input instr_t ins, input logic mem_allow);
    @(posedge clk); #2;
    applyStimulus(1'b1, ins, mem_allow);
    @(posedge clk); #2;
    applyStimulus(1'b0, '0, mem_allow);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    reset  = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_allow_in", {127'b0, bus.EX_allow_in}, 128'h1);
    checkOutput("rst_to_mem_valid", {127'b0, bus.EX_to_MEM_valid}, 128'h0);
    checkOutput("rst_to_mem_data", 128'(bus.to_MEM_data), 128'h0);
    checkOutput("rst_forward", 128'(bus.EX_forward), 128'h0);
    checkOutput("rst_sram", 128'({bus.data_sram_en, bus.data_sram_we, bus.data_sram_addr, bus.data_sram_wdata}), 128'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    issue(mk(32'h1C000010, 32'h7FFFFFFF, 32'h1, 32'h0, 12'h001, 0, 0, 0, 0, 5'd5), 1'b1);
    checkOutput("add_valid", {127'b0, bus.EX_to_MEM_valid}, 128'h1);
    checkOutput("add_result", 128'(bus.to_MEM_data[38:7]), 128'h80000000);
    checkOutput("add_forward", 128'(bus.EX_forward), 128'({5'd5, 32'h80000000, 1'b0}));

    issue(mk(32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 12'h004, 0, 0, 0, 0, 5'd3), 1'b1);
    checkOutput("slt_neg", 128'(bus.to_MEM_data[38:7]), 128'h1);
    issue(mk(32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 12'h008, 0, 0, 0, 0, 5'd3), 1'b1);
    checkOutput("sltu_big", 128'(bus.to_MEM_data[38:7]), 128'h0);
    issue(mk(32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 12'h004, 0, 0, 0, 0, 5'd3), 1'b1);
    checkOutput("slt_swap", 128'(bus.to_MEM_data[38:7]), 128'h0);
    issue(mk(32'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 12'h008, 0, 0, 0, 0, 5'd3), 1'b1);
    checkOutput("sltu_swap", 128'(bus.to_MEM_data[38:7]), 128'h1);

    issue(mk(32'h0, 32'h80000000, 32'h0, 32'd31, 12'h400, 0, 1, 0, 0, 5'd4), 1'b1);
    checkOutput("sra_31", 128'(bus.to_MEM_data[38:7]), 128'hFFFFFFFF);
    issue(mk(32'h0, 32'h80000000, 32'h0, 32'd31, 12'h200, 0, 1, 0, 0, 5'd4), 1'b1);
    checkOutput("srl_31", 128'(bus.to_MEM_data[38:7]), 128'h1);

    issue(mk(32'h1C000020, 32'h1000, 32'hDEADBEEF, 32'h8, 12'h001, 0, 1, 1, 0, 5'd0), 1'b0);
    for (int s = 0; s < 3; s++) begin
      if (s != 0) @(negedge clk);
      checkOutput("st_stall_we", 128'(bus.data_sram_we), 128'h0);
      checkOutput("st_stall_allow_in", {127'b0, bus.EX_allow_in}, 128'h0);
    end
    @(posedge clk); #2;
    bus.MEM_allow_in = 1'b1;
    @(negedge clk);
    checkOutput("st_release_we", 128'(bus.data_sram_we), 128'hF);
    checkOutput("st_release_addr", 128'(bus.data_sram_addr), 128'h1008);
    checkOutput("st_release_wdata", 128'(bus.data_sram_wdata), 128'hDEADBEEF);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("st_after_we", 128'(bus.data_sram_we), 128'h0);

    issue(mk(32'h1C000030, 32'h2000, 32'h0, 32'h4, 12'h001, 0, 1, 0, 1, 5'd7), 1'b1);
    checkOutput("ld_forward", 128'(bus.EX_forward), 128'({5'd7, 32'h2004, 1'b1}));
    checkOutput("ld_sram_en", {127'b0, bus.data_sram_en}, 128'h1);
    @(posedge clk); #2;
    @(negedge clk);
    checkOutput("ld_gone_forward", 128'(bus.EX_forward), 128'h0);
    checkOutput("ld_gone_sram_en", {127'b0, bus.data_sram_en}, 128'h0);

    issue(mk(32'h1C000000, 32'h0, 32'h0, 32'h4, 12'h001, 1, 1, 0, 0, 5'd1), 1'b1);
    checkOutput("bl_result", 128'(bus.to_MEM_data[38:7]), 128'h1C000004);
    checkOutput("bl_dest", 128'(bus.to_MEM_data[5:1]), 128'h1);
    checkOutput("bl_pc", 128'(bus.to_MEM_data[70:39]), 128'h1C000000);
    #1;
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", {127'b0, bus.EX_to_MEM_valid}, 128'h0);
    checkOutput("rst_mid_allow_in", {127'b0, bus.EX_allow_in}, 128'h1);
    checkOutput("rst_mid_sram_en", {127'b0, bus.data_sram_en}, 128'h0);
    @(posedge clk); #2;
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
